// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - per-channel brightness fader with PWM output, active-low LED drive
// Levels step toward an on/off target once per fade tick; a free-running PWM counter renders them.
module led_fade_driver #(
    parameter int NUM_LEDS = 6,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 105468,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                load,
    output logic [NUM_LEDS-1:0] led_n,
    output logic                busy
);

    localparam int LVL_MAX = 2**PWM_BITS - 1;
    localparam int TW      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PWM_BITS:0] STEP_W    = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS:0] LVL_MAX_W = (PWM_BITS+1)'(LVL_MAX);
    localparam logic [TW-1:0]     TICK_LAST = TW'(FADE_DIV - 1);

    logic [NUM_LEDS-1:0] pattern_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [TW-1:0]       tick_cnt;
    logic                tick;

    logic [PWM_BITS-1:0] level    [NUM_LEDS];
    logic [PWM_BITS-1:0] lvl_next [NUM_LEDS];
    logic [PWM_BITS-1:0] tgt      [NUM_LEDS];
    logic [PWM_BITS:0]   up_sum   [NUM_LEDS];
    logic [NUM_LEDS-1:0] on;

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            tgt[i]      = pattern_q[i] ? '1 : '0;
            up_sum[i]   = {1'b0, level[i]} + STEP_W;
            lvl_next[i] = level[i];
            // Up-step is one bit wider so overshoot past LVL_MAX is caught and clamped
            if (level[i] < tgt[i]) begin
                lvl_next[i] = (up_sum[i] > LVL_MAX_W) ? '1 : up_sum[i][PWM_BITS-1:0];
            end else if (level[i] > tgt[i]) begin
                lvl_next[i] = ({1'b0, level[i]} < STEP_W) ? '0
                            : level[i] - STEP_W[PWM_BITS-1:0];
            end
            on[i] = (pwm_cnt < level[i]);
            busy  = busy | (level[i] != tgt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= '0;
            pwm_cnt   <= '0;
            tick_cnt  <= '0;
            led_n     <= '1;
            for (int i = 0; i < NUM_LEDS; i++) begin
                level[i] <= '0;
            end
        end else begin
            // Level step uses the pre-edge pattern_q, so a coincident load lands on the next tick
            if (load) begin
                pattern_q <= pattern_in;
            end
            pwm_cnt  <= pwm_cnt + 1'b1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (tick) begin
                    level[i] <= lvl_next[i];
                end
            end
            led_n <= ~on;
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - randomized and directed checks of led_fade_driver against a cycle model
// Model: pwm phase and tick phase are derived from clocks since reset; levels use saturating arithmetic.
module tb_led_fade_driver;

    localparam int N  = 6;
    localparam int FD = 4;
    localparam int ST = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] pattern_in = '0;
    logic [N-1:0] led_n;
    logic         busy;

    logic         s_load = 1'b0;
    logic [N-1:0] s_pat = '0;
    logic [N-1:0] s_led_n;
    logic         s_busy;

    int n_checks = 0;
    int n_pass   = 0;

    int           m_lvl [N];
    logic [N-1:0] m_pat;
    logic [N-1:0] m_led;
    int           m_cnt;

    always #5 clk = ~clk;

    led_fade_driver #(.NUM_LEDS(N), .PWM_BITS(8), .FADE_DIV(FD), .STEP(ST)) u_dut (
        .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .load(load),
        .led_n(led_n), .busy(busy)
    );

    led_fade_driver #(.NUM_LEDS(N), .PWM_BITS(8), .FADE_DIV(512), .STEP(128)) u_slow (
        .clk(clk), .rst_n(rst_n), .pattern_in(s_pat), .load(s_load),
        .led_n(s_led_n), .busy(s_busy)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pat = '0;
            m_led = '1;
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_lvl[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) m_led[i] = !((m_cnt % 256) < m_lvl[i]);
            if (m_cnt % FD == FD - 1) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pat[i] && m_lvl[i] < 255)      m_lvl[i] = (m_lvl[i] + ST > 255) ? 255 : m_lvl[i] + ST;
                    else if (!m_pat[i] && m_lvl[i] > 0)  m_lvl[i] = (m_lvl[i] < ST) ? 0 : m_lvl[i] - ST;
                end
            end
            if (load) m_pat = pattern_in;
            m_cnt = m_cnt + 1;
        end
    end

    function automatic logic m_busy();
        logic b = 1'b0;
        for (int i = 0; i < N; i++) b = b | (m_lvl[i] != (m_pat[i] ? 255 : 0));
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== 6'h3F || busy !== 1'b0)
                $display("FAIL reset_hold: led_n=%h busy=%b expected led_n=3f busy=0", led_n, busy);
            else n_pass++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== 6'h3F || busy !== 1'b0 || led_n !== m_led)
                $display("FAIL reset_release: led_n=%h busy=%b expected led_n=3f busy=0", led_n, busy);
            else n_pass++;
        end
    endtask

    task automatic test_duty_half();
        int low = 0;
        s_pat = 6'b000001;
        s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        n_checks++;
        if (s_busy !== 1'b1) $display("FAIL slow_busy_rise: busy=%b expected 1", s_busy);
        else n_pass++;
        repeat (600) @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (s_led_n[0] === 1'b0) low++;
            n_checks++;
            if (s_led_n[5:1] !== 5'h1F) $display("FAIL slow_other_leds: led_n=%h expected upper bits 1f", s_led_n);
            else n_pass++;
        end
        n_checks++;
        if (low != 128) $display("FAIL duty_128: low cycles=%0d expected 128", low);
        else n_pass++;
    endtask

    task automatic test_fade_in();
        pattern_in = 6'b000001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL fade_in_busy_rise: busy=%b expected 1", busy);
        else n_pass++;
        repeat (24) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== m_led || busy !== m_busy() || led_n[5:1] !== 5'h1F)
                $display("FAIL fade_in: led_n=%h busy=%b expected led_n=%h busy=%b", led_n, busy, m_led, m_busy());
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL fade_in_done: busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_duty_full();
        int low = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (led_n[0] === 1'b0) low++;
        end
        n_checks++;
        if (low != 255) $display("FAIL duty_255: low cycles=%0d expected 255", low);
        else n_pass++;
    endtask

    task automatic test_fade_out();
        pattern_in = 6'h3F;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (30) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== m_led || busy !== m_busy())
                $display("FAIL all_on: led_n=%h busy=%b expected led_n=%h busy=%b", led_n, busy, m_led, m_busy());
            else n_pass++;
        end
        pattern_in = 6'h00;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (30) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== m_led || busy !== m_busy())
                $display("FAIL fade_out: led_n=%h busy=%b expected led_n=%h busy=%b", led_n, busy, m_led, m_busy());
            else n_pass++;
        end
        repeat (260) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== 6'h3F || busy !== 1'b0)
                $display("FAIL fade_out_dark: led_n=%h busy=%b expected led_n=3f busy=0", led_n, busy);
            else n_pass++;
        end
    endtask

    task automatic test_reversal();
        pattern_in = 6'b000001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 40 && m_lvl[0] != 128; k++) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== m_led || busy !== m_busy())
                $display("FAIL rev_rise: led_n=%h busy=%b expected led_n=%h busy=%b", led_n, busy, m_led, m_busy());
            else n_pass++;
        end
        for (int k = 0; k < 8 && (m_cnt % FD) != FD - 1; k++) @(negedge clk);
        n_checks++;
        if (m_lvl[0] != 128 || (m_cnt % FD) != FD - 1)
            $display("FAIL rev_setup: level=%0d phase=%0d expected 128 and %0d", m_lvl[0], m_cnt % FD, FD - 1);
        else n_pass++;
        pattern_in = 6'b000000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (m_lvl[0] != 192 || busy !== 1'b1)
            $display("FAIL rev_coincident: level=%0d busy=%b expected 192 busy=1", m_lvl[0], busy);
        else n_pass++;
        repeat (30) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== m_led || busy !== m_busy())
                $display("FAIL rev_fall: led_n=%h busy=%b expected led_n=%h busy=%b", led_n, busy, m_led, m_busy());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        pattern_in = 6'h3F;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 40 && m_lvl[0] != 128; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (led_n !== 6'h3F || busy !== 1'b0)
            $display("FAIL reset_mid: led_n=%h busy=%b expected led_n=3f busy=0", led_n, busy);
        else n_pass++;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== 6'h3F || busy !== 1'b0)
                $display("FAIL reset_mid_idle: led_n=%h busy=%b expected led_n=3f busy=0", led_n, busy);
            else n_pass++;
        end
        pattern_in = 6'h3F;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (300) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== m_led || busy !== m_busy())
                $display("FAIL reset_mid_refade: led_n=%h busy=%b expected led_n=%h busy=%b", led_n, busy, m_led, m_busy());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        repeat (2000) begin
            @(negedge clk);
            n_checks++;
            if (led_n !== m_led || busy !== m_busy())
                $display("FAIL random: led_n=%h busy=%b expected led_n=%h busy=%b", led_n, busy, m_led, m_busy());
            else n_pass++;
            load = ($urandom_range(0, 9) == 0);
            pattern_in = N'($urandom);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_duty_half();
        test_fade_in();
        test_duty_full();
        test_fade_out();
        test_reversal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
